// File: rtl/mux_rr_n_pkg.sv
// Shared constants and helpers for the N-channel registered round-robin multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width never collapses to zero, even for a 1- or 2-channel build.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/mux_rr_n_if.sv
// Producer-side and consumer-side handshake bundle of the multiplexer.
interface mux_rr_n_if
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SELW = clog2_min1(N);

    logic                mode;
    logic [SELW-1:0]     sel;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [N*W-1:0]      in_data;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [SELW-1:0]     out_ch;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/mux_rr_n_arbiter.sv
// Rotating-priority arbiter: the first requester at or after ptr (mod N) wins.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt
);

    logic [SELW-1:0] idx_s;
    logic            hit_s;
    logic            found_s;

    // Walk the channels starting at ptr, wrapping at N rather than 2^SELW.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s        = SELW'((int'(ptr) + k) % N);
            hit_s        = en & ~found_s & req[idx_s];
            gnt[idx_s]   = gnt[idx_s] | hit_s;
            found_s      = found_s | hit_s;
        end
    end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel, W-bit registered multiplexer with fixed-select or round-robin
// channel choice and valid/ready handshakes on every port.
module mux_rr_n
    import mux_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    mux_rr_n_if.slave   bus
);

    localparam int SELW = clog2_min1(N);

    logic                load_s;
    logic                rr_en_s;
    logic [N-1:0]        fixed_gnt_s;
    logic [N-1:0]        rr_gnt_s;
    logic [N-1:0]        grant_s;
    logic                any_s;
    logic [W-1:0]        data_s;
    logic [SELW-1:0]     ch_s;

    logic                out_valid_r;
    logic [W-1:0]        out_data_r;
    logic [SELW-1:0]     out_ch_r;
    logic [SELW-1:0]     rr_ptr_r;

    // The register can take a word when empty or when its word leaves this cycle.
    assign load_s  = !out_valid_r || bus.out_ready;
    assign rr_en_s = load_s && (bus.mode == MODE_RR);

    rr_arbiter #(.N(N)) u_arb (
        .req (bus.in_valid),
        .ptr (rr_ptr_r),
        .en  (rr_en_s),
        .gnt (rr_gnt_s)
    );

    // Fixed-select grant; out-of-range sel grants nobody.
    always_comb begin
        fixed_gnt_s = '0;
        if (load_s && (bus.mode == MODE_FIXED) && (int'(bus.sel) < N)) begin
            fixed_gnt_s[bus.sel] = bus.in_valid[bus.sel];
        end else begin
            fixed_gnt_s = '0;
        end
    end

    // One-hot grant to data/channel selection by AND-OR.
    always_comb begin
        grant_s = (bus.mode == MODE_RR) ? rr_gnt_s : fixed_gnt_s;
        any_s   = |grant_s;
        data_s  = '0;
        ch_s    = '0;
        for (int i = 0; i < N; i++) begin
            data_s = data_s | (bus.in_data[i*W +: W] & {W{grant_s[i]}});
            ch_s   = ch_s   | (SELW'(i) & {SELW{grant_s[i]}});
        end
    end

    // Producers see no accept while reset is held.
    assign bus.in_ready = rst_n ? grant_s : {N{1'b0}};

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ch_r    <= '0;
            rr_ptr_r    <= '0;
        end else if (load_s) begin
            if (any_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= data_s;
                out_ch_r    <= ch_s;
                if (bus.mode == MODE_RR) begin
                    rr_ptr_r <= (ch_s == SELW'(N-1)) ? '0 : ch_s + SELW'(1);
                end else begin
                    rr_ptr_r <= rr_ptr_r;
                end
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_ch    = out_ch_r;

endmodule

// File: tb/tb_mux_rr_n.sv
// Randomised and directed bench for mux_rr_n against a cycle-level reference model.
module tb_mux_rr_n;
    import mux_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_n_if #(.N(N), .W(W)) bus ();

    mux_rr_n #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_en      = 1'b0;

    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    function automatic logic [N-1:0] model_gnt();
        logic [N-1:0] g = '0;
        int idx;
        if (!rst_n) return g;
        if (m_valid && !bus.out_ready) return g;
        if (bus.mode == MODE_FIXED) begin
            if (int'(bus.sel) < N && bus.in_valid[bus.sel]) g[bus.sel] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (bus.in_valid[idx]) begin
                    g[idx] = 1'b1;
                    break;
                end
            end
        end
        return g;
    endfunction

    function automatic int grant_idx();
        logic [N-1:0] g = model_gnt();
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    // Reference model state advances on the same edges as the register.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ch    <= 0;
            m_ptr   <= 0;
        end else if (grant_idx() >= 0) begin
            m_valid <= 1'b1;
            m_data  <= bus.in_data[grant_idx()*W +: W];
            m_ch    <= grant_idx();
            if (bus.mode == MODE_RR) m_ptr <= (grant_idx() + 1) % N;
        end else if (!m_valid || bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",  32'(bus.in_ready),  32'(model_gnt()));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            check("out_data",  32'(bus.out_data),  32'(m_data));
            check("out_ch",    32'(bus.out_ch),    32'(m_ch));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic std_data();
        bus.in_data = 32'hA3A2_A1A0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic lit_out(input string name, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({name, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({name, "_data"},  32'(bus.out_data),  32'(d));
        check({name, "_ch"},    32'(bus.out_ch),    32'(c));
    endtask

    int seq3 [6] = '{0, 1, 2, 3, 0, 1};
    int seq4 [4] = '{1, 3, 1, 3};

    initial begin
        bus.mode      = MODE_FIXED;
        bus.sel       = 2'd0;
        bus.in_valid  = 4'b0000;
        bus.out_ready = 1'b0;
        std_data();
        chk_en = 1'b1;

        // 1: reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.mode      = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = 1'($urandom);
            tick();
            lit_out("rst", 1'b0, 8'h00, 2'd0);
            check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        end
        std_data();
        bus.in_valid = 4'b0000;
        rst_n = 1'b1;
        tick();

        // 2: fixed select on channel 2
        bus.mode = MODE_FIXED; bus.sel = 2'd2; bus.in_valid = 4'b1111; bus.out_ready = 1'b1;
        #1 check("fix_in_ready", 32'(bus.in_ready), 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            lit_out("fix", 1'b1, 8'hA2, 2'd2);
            check("fix_in_ready", 32'(bus.in_ready), 32'h4);
        end

        // 3: round-robin across all channels
        bus.mode = MODE_RR;
        for (int i = 0; i < 6; i++) begin
            tick();
            lit_out("rr_all", 1'b1, 8'(8'hA0 + seq3[i]), 2'(seq3[i]));
        end

        // 4: sparse requesters, then idle
        do_reset();
        bus.mode = MODE_RR; bus.in_valid = 4'b1010; bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            lit_out("rr_sparse", 1'b1, 8'(8'hA0 + seq4[i]), 2'(seq4[i]));
        end
        bus.in_valid = 4'b0000;
        tick();
        lit_out("rr_idle", 1'b0, 8'hA3, 2'd3);

        // 5: backpressure holds word and pointer
        do_reset();
        bus.in_valid = 4'b1111;
        tick();
        tick();
        lit_out("bp_pre", 1'b1, 8'hA1, 2'd1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            lit_out("bp_hold", 1'b1, 8'hA1, 2'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(bus.in_ready), 32'h4);
        tick();
        lit_out("bp_next", 1'b1, 8'hA2, 2'd2);

        // 6: async reset pulse between edges
        tick();
        #1 rst_n = 1'b0;
        #1 check("arst_valid", 32'(bus.out_valid), 32'h0);
        check("arst_in_ready", 32'(bus.in_ready), 32'h0);
        #2 rst_n = 1'b1;
        tick();
        lit_out("arst_first", 1'b1, 8'hA0, 2'd0);
        bus.mode = MODE_FIXED; bus.sel = 2'd3;
        tick();
        lit_out("fix3", 1'b1, 8'hA3, 2'd3);
        bus.out_ready = 1'b0; bus.mode = MODE_RR;
        for (int i = 0; i < 2; i++) begin
            tick();
            lit_out("mode_chg_hold", 1'b1, 8'hA3, 2'd3);
        end

        // Random traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            bus.mode      = 1'($urandom);
            bus.sel       = 2'($urandom);
            bus.in_valid  = 4'($urandom);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
